// File: rtl/mcu_reset_seq.sv
// mcu_reset_seq: MCU reset sequencer.
// Runs power-on / lock-loss full CPU reset (with post-lock stretch), debounced
// soft-reset button and watchdog soft-reset pulse. seq_state exposes the FSM
// state for debug and checker binding.
// Optional feature: define MCU_RST_CAUSE_EN to implement the rst_cause register;
// when undefined rst_cause is tied to 2'b00 and no cause register exists.
module mcu_reset_seq #(
    parameter int unsigned DEB_CYC     = 40000,
    parameter int unsigned STRETCH_CYC = 1024,
    parameter int unsigned SOFT_CYC    = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       soft_btn_n,
    input  logic       wdt_rst_req,
    output logic       cpu_rstn,
    output logic       soft_rstn,
    output logic       seq_busy,
    output logic [1:0] rst_cause,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_LOCK    = 3'd1,
        ST_STRETCH = 3'd2,
        ST_RUN     = 3'd3,
        ST_SOFT    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST    = CNT_W'(SOFT_CYC - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] seq_cnt;
    logic [CNT_W-1:0] cnt_nx;

    logic             lock_m;
    logic             lock_s;
    logic             btn_m;
    logic             btn_s;
    logic             btn_deb;
    logic             btn_deb_q;
    logic [CNT_W-1:0] deb_cnt;
    logic             press;

    assign seq_state = state;

    // Two-flop synchronisers. The lock chain is held clear during HOLD so that
    // lock qualification always spans the full synchroniser latency from LOCK.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            btn_m  <= 1'b1;
            btn_s  <= 1'b1;
        end else begin
            lock_m <= (state == ST_HOLD) ? 1'b0 : pll_lock;
            lock_s <= lock_m;
            btn_m  <= soft_btn_n;
            btn_s  <= btn_m;
        end
    end

    // Debounce: accept a new button level after DEB_CYC consecutive differing cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_deb   <= 1'b1;
            btn_deb_q <= 1'b1;
            deb_cnt   <= '0;
        end else begin
            btn_deb_q <= btn_deb;
            if (btn_s == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_deb <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

    // One-cycle press event on the falling edge of the debounced level.
    assign press = btn_deb_q & ~btn_deb;

    // Next-state decode; lock loss outranks watchdog, which outranks the button.
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        case (state)
            ST_HOLD: begin
                state_nx = ST_LOCK;
            end
            ST_LOCK: begin
                if (lock_s) state_nx = ST_STRETCH;
            end
            ST_STRETCH: begin
                if (!lock_s)                    state_nx = ST_LOCK;
                else if (seq_cnt == STRETCH_LAST) state_nx = ST_RUN;
                else                            cnt_nx   = seq_cnt + CNT_W'(1);
            end
            ST_RUN: begin
                if (!lock_s)          state_nx = ST_LOCK;
                else if (wdt_rst_req) state_nx = ST_SOFT;
                else if (press)       state_nx = ST_SOFT;
            end
            ST_SOFT: begin
                if (!lock_s)                   state_nx = ST_LOCK;
                else if (seq_cnt == SOFT_LAST) state_nx = ST_RUN;
                else                           cnt_nx   = seq_cnt + CNT_W'(1);
            end
            default: begin
                state_nx = ST_HOLD;
            end
        endcase
    end

    // FSM state, shared sequence counter and outputs registered from next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_HOLD;
            seq_cnt   <= '0;
            cpu_rstn  <= 1'b0;
            soft_rstn <= 1'b1;
            seq_busy  <= 1'b1;
        end else begin
            state     <= state_nx;
            seq_cnt   <= cnt_nx;
            cpu_rstn  <= (state_nx == ST_RUN) || (state_nx == ST_SOFT);
            soft_rstn <= (state_nx != ST_SOFT);
            seq_busy  <= (state_nx != ST_RUN);
        end
    end

`ifdef MCU_RST_CAUSE_EN
    logic [1:0] cause_q;

    // Record the reason for the most recent reset taken out of RUN or SOFT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cause_q <= 2'b00;
        end else if (((state == ST_RUN) || (state == ST_SOFT)) && !lock_s) begin
            cause_q <= 2'b01;
        end else if ((state == ST_RUN) && wdt_rst_req) begin
            cause_q <= 2'b11;
        end else if ((state == ST_RUN) && press) begin
            cause_q <= 2'b10;
        end
    end

    assign rst_cause = cause_q;
`else
    assign rst_cause = 2'b00;
`endif

endmodule

// File: tb/tb_mcu_reset_seq.sv
// tb_mcu_reset_seq: directed scenarios plus randomized traffic for
// mcu_reset_seq, checked against a countdown-based reference model.
module tb_mcu_reset_seq;

    localparam int DEB = 4;
    localparam int STR = 8;
    localparam int SFT = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       soft_btn_n;
    logic       wdt_rst_req;
    logic       cpu_rstn;
    logic       soft_rstn;
    logic       seq_busy;
    logic [1:0] rst_cause;
    logic [2:0] seq_state;

    int total = 0;
    int bad   = 0;

    mcu_reset_seq #(
        .DEB_CYC    (DEB),
        .STRETCH_CYC(STR),
        .SOFT_CYC   (SFT),
        .CNT_W      (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .soft_btn_n (soft_btn_n),
        .wdt_rst_req(wdt_rst_req),
        .cpu_rstn   (cpu_rstn),
        .soft_rstn  (soft_rstn),
        .seq_busy   (seq_busy),
        .rst_cause  (rst_cause),
        .seq_state  (seq_state)
    );

    // ---------------- clock / safety limit ----------------
    initial forever #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL sim_time_limit: observed=expired required=finished");
        $fatal(1, "time limit");
    end

    // ---------------- reference model ----------------
    typedef enum {M_HOLD, M_LOCK, M_COUNT, M_RUN, M_PULSE} mode_t;

    mode_t      m_mode;
    int         m_remain;
    logic [1:0] m_cause;
    bit         m_deb;
    bit         m_press;
    bit         lock_q[$];
    bit         btn_q[$];
    bit         deb_run[$];
    logic [4:0] exp_q[$];

    function automatic logic [1:0] cause_view(input logic [1:0] c);
`ifdef MCU_RST_CAUSE_EN
        return c;
`else
        return 2'b00;
`endif
    endfunction

    task automatic model_reset();
        m_mode   = M_HOLD;
        m_remain = 0;
        m_cause  = 2'b00;
        m_deb    = 1'b1;
        m_press  = 1'b0;
        lock_q   = '{1'b0, 1'b0};
        btn_q    = '{1'b1, 1'b1};
        deb_run.delete();
    endtask

    task automatic push_exp();
        logic c, s, b;
        c = (m_mode == M_RUN) || (m_mode == M_PULSE);
        s = (m_mode != M_PULSE);
        b = (m_mode != M_RUN);
        exp_q.push_back({c, s, b, cause_view(m_cause)});
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        bit lk, bs, was_hold, fell;
        if (!reset) begin
            model_reset();
            push_exp();
            return;
        end
        was_hold = (m_mode == M_HOLD);
        lk = lock_q.pop_front();
        lock_q.push_back(was_hold ? 1'b0 : pll_lock);
        bs = btn_q.pop_front();
        btn_q.push_back(soft_btn_n);
        case (m_mode)
            M_HOLD:  m_mode = M_LOCK;
            M_LOCK:  if (lk) begin m_mode = M_COUNT; m_remain = STR; end
            M_COUNT: begin
                if (!lk) m_mode = M_LOCK;
                else begin
                    m_remain--;
                    if (m_remain == 0) m_mode = M_RUN;
                end
            end
            M_RUN: begin
                if (!lk) begin m_mode = M_LOCK; m_cause = 2'b01; end
                else if (wdt_rst_req) begin m_mode = M_PULSE; m_remain = SFT; m_cause = 2'b11; end
                else if (m_press) begin m_mode = M_PULSE; m_remain = SFT; m_cause = 2'b10; end
            end
            M_PULSE: begin
                if (!lk) begin m_mode = M_LOCK; m_cause = 2'b01; end
                else begin
                    m_remain--;
                    if (m_remain == 0) m_mode = M_RUN;
                end
            end
            default: m_mode = M_HOLD;
        endcase
        fell = 1'b0;
        if (bs == m_deb) deb_run.delete();
        else begin
            deb_run.push_back(bs);
            if (deb_run.size() == DEB) begin
                fell  = m_deb;
                m_deb = bs;
                deb_run.delete();
            end
        end
        m_press = fell;
        push_exp();
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [4:0] e;
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk("cpu_rstn", cpu_rstn, e[4]);
        chk("soft_rstn", soft_rstn, e[3]);
        chk("seq_busy", seq_busy, e[2]);
        chk("rst_cause", rst_cause, e[1:0]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    int pulses, width, cpu_drop;
    logic prev_soft;
    logic [1:0] cause_in_pulse;

    task automatic monitor_tick();
        tick();
        if (prev_soft && !soft_rstn) pulses++;
        if (!soft_rstn) begin
            width++;
            cause_in_pulse = rst_cause;
        end
        if (!cpu_rstn) cpu_drop++;
        prev_soft = soft_rstn;
    endtask

    task automatic monitor_clear();
        pulses = 0; width = 0; cpu_drop = 0; prev_soft = 1'b1; cause_in_pulse = 2'b00;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic latency_to_cpu(output int n);
        n = 0;
        while (cpu_rstn !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (m_mode != M_RUN && n < 60) begin
            tick();
            n++;
        end
        chk("reach_run", cpu_rstn, 1);
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        int n, lock_hold;
        reset = 1'b0; pll_lock = 1'b1; soft_btn_n = 1'b1; wdt_rst_req = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_cpu_rstn", cpu_rstn, 0);
        chk("rst_soft_rstn", soft_rstn, 1);
        chk("rst_seq_busy", seq_busy, 1);
        chk("rst_cause", rst_cause, 0);

        // power-on with lock already present
        reset = 1'b1;
        latency_to_cpu(n);
        chk("por_latency", n, 12);
        chk("por_busy_fall", seq_busy, 0);

        // lock glitch at stretch count 5 restarts the stretch
        apply_reset();
        n = 0;
        while (!(m_mode == M_COUNT && m_remain == STR - 5) && n < 40) begin tick(); n++; end
        chk("reach_count5", cpu_rstn, 0);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        latency_to_cpu(n);
        chk("stretch_restart_latency", n, 11);

        // lock loss in RUN, then relock from LOCK
        pll_lock = 1'b0;
        repeat (4) tick();
        chk("lockloss_cpu", cpu_rstn, 0);
        chk("lockloss_cause", rst_cause, cause_view(2'b01));
        pll_lock = 1'b1;
        latency_to_cpu(n);
        chk("relock_latency", n, 11);

        // bouncing button then a solid press
        monitor_clear();
        for (int i = 0; i < 5; i++) begin
            soft_btn_n = 1'b0; repeat (2) monitor_tick();
            soft_btn_n = 1'b1; repeat (2) monitor_tick();
        end
        chk("bounce_no_pulse", pulses, 0);
        soft_btn_n = 1'b0;
        repeat (20) monitor_tick();
        chk("btn_pulse_count", pulses, 1);
        chk("btn_pulse_width", width, SFT);
        chk("btn_cpu_held", cpu_drop, 0);
        chk("btn_cause", cause_in_pulse, cause_view(2'b10));
        soft_btn_n = 1'b1;
        repeat (10) tick();

        // watchdog and lock loss on the same RUN cycle
        monitor_clear();
        pll_lock = 1'b0;
        repeat (2) monitor_tick();
        wdt_rst_req = 1'b1;
        monitor_tick();
        wdt_rst_req = 1'b0;
        chk("coinc_cpu", cpu_rstn, 0);
        chk("coinc_soft", soft_rstn, 1);
        chk("coinc_cause", rst_cause, cause_view(2'b01));
        repeat (4) monitor_tick();
        chk("coinc_no_pulse", pulses, 0);
        pll_lock = 1'b1;
        wait_run();

        // watchdog pulse, repeated watchdog during SOFT ignored
        wdt_rst_req = 1'b1;
        tick();
        wdt_rst_req = 1'b0;
        chk("wdt_soft_fall", soft_rstn, 0);
        chk("wdt_cause", rst_cause, cause_view(2'b11));
        monitor_clear();
        prev_soft = 1'b0;
        width = 1;
        wdt_rst_req = 1'b1;
        monitor_tick();
        wdt_rst_req = 1'b0;
        repeat (8) monitor_tick();
        chk("wdt_pulse_width", width, SFT);
        chk("wdt_no_second_pulse", pulses, 0);

        // asynchronous reset in the middle of SOFT
        wdt_rst_req = 1'b1;
        tick();
        wdt_rst_req = 1'b0;
        tick();
        chk("mid_soft_low", soft_rstn, 0);
        #2 reset = 1'b0;
        #1;
        chk("async_cpu", cpu_rstn, 0);
        chk("async_soft", soft_rstn, 1);
        chk("async_busy", seq_busy, 1);
        chk("async_cause", rst_cause, 0);
        model_reset();
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        latency_to_cpu(n);
        chk("restart_latency", n, 12);

        // randomized traffic
        lock_hold = 0;
        for (int i = 0; i < 800; i++) begin
            if (lock_hold > 0) begin
                lock_hold--;
                if (lock_hold == 0) pll_lock = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                pll_lock  = 1'b0;
                lock_hold = $urandom_range(1, 6);
            end
            wdt_rst_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) soft_btn_n = ~soft_btn_n;
            tick();
        end
        wdt_rst_req = 1'b0;
        pll_lock    = 1'b1;
        soft_btn_n  = 1'b1;
        repeat (30) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcu_reset_seq.md
MCU_RESET_SEQ -- requirements
Module: mcu_reset_seq

Interface
REQ-001 Parameter DEB_CYC, default 40000: number of consecutive stable cycles needed to accept a soft-button level (5 ms at 8 MHz).
REQ-002 Parameter STRETCH_CYC, default 1024: cycles `cpu_rstn` is held low after `pll_lock` is stable.
REQ-003 Parameter SOFT_CYC, default 64: width of a `soft_rstn` low pulse, in cycles.
REQ-004 Parameter CNT_W, default 16: width of all internal counters; every count parameter SHALL be below 2^CNT_W.
REQ-005 `clock`  in  1: single block clock, the PLL 8 MHz output; all logic is on its rising edge.
REQ-006 `reset`  in  1: asynchronous, active-low reset.
REQ-007 `pll_lock`  in  1: PLL lock, asynchronous to `clock`.
REQ-008 `soft_btn_n`  in  1: raw soft-reset button, active-low, asynchronous and bouncing.
REQ-009 `wdt_rst_req`  in  1: watchdog reset request, a one-cycle pulse synchronous to `clock`.
REQ-010 `cpu_rstn`  out  1: registered full CPU reset, active-low.
REQ-011 `soft_rstn`  out  1: registered soft-reset pulse, active-low.
REQ-012 `seq_busy`  out  1: registered; high whenever the FSM is not in RUN.
REQ-013 `rst_cause`  out  2: last reset cause: 00 = POR, 01 = lock loss, 10 = button, 11 = watchdog.

Function
REQ-014 `pll_lock` and `soft_btn_n` SHALL each pass through a 2-FF synchroniser, giving `lock_s` and `btn_s`.
REQ-015 Debounce: `btn_deb` SHALL take the value of `btn_s` only after `btn_s` has differed from `btn_deb` for DEB_CYC consecutive cycles; any glitch shorter than that clears the counter.
REQ-016 A press event is one cycle, generated on the 1→0 transition of `btn_deb`; a new press requires `btn_deb` to return to 1 first.
REQ-017 FSM states: HOLD, LOCK, STRETCH, RUN, SOFT; the state is HOLD while `reset` is low.
REQ-018 HOLD→LOCK after exactly one cycle.
REQ-019 LOCK→STRETCH when `lock_s` = 1; the stretch counter SHALL be cleared on entry.
REQ-020 STRETCH→RUN when the counter reaches STRETCH_CYC-1; if `lock_s` = 0 in any STRETCH cycle, the FSM SHALL go to LOCK and restart the count.
REQ-021 RUN→LOCK when `lock_s` = 0, with `rst_cause` = 01.
REQ-022 RUN→SOFT on a press event (`rst_cause` = 10) or on `wdt_rst_req` (`rst_cause` = 11).
REQ-023 SOFT→RUN after SOFT_CYC cycles; `lock_s` = 0 in SOFT SHALL go to LOCK and end the soft pulse.
REQ-024 Priority: lock loss > watchdog > button when events coincide.
REQ-025 `wdt_rst_req` and press events arriving outside RUN SHALL be ignored, not queued.
REQ-026 `cpu_rstn` = 1 only in RUN and SOFT; `soft_rstn` = 0 only in SOFT; both are registered from the next-state decode.
REQ-027 Latency: `cpu_rstn` SHALL rise exactly 2 + 1 + STRETCH_CYC rising edges after `pll_lock` rises while the FSM is in LOCK.
REQ-028 `soft_rstn` SHALL fall exactly 1 edge after `wdt_rst_req` is sampled high in RUN.

Reset
REQ-029 While `reset` = 0, the block SHALL force asynchronously: state = HOLD, all counters = 0, `lock_s` = 0, `btn_s` = 1, `btn_deb` = 1, `cpu_rstn` = 0, `soft_rstn` = 1, `seq_busy` = 1, `rst_cause` = 00.
REQ-030 Reset deassertion mid-sequence SHALL restart the sequence from HOLD, with no residual count.

Configuration
REQ-031 Macro MCU_RST_CAUSE_EN defined: the `rst_cause` register is implemented per REQ-013 and REQ-021–REQ-022.
REQ-032 Macro MCU_RST_CAUSE_EN undefined: `rst_cause` SHALL be a constant 00 and no cause register is synthesised; all other behaviour is unchanged.

Verification
REQ-033 Scenario (STRETCH_CYC = 8): release `reset` with `pll_lock` = 1 → `cpu_rstn` rises 12 edges after reset release (1 HOLD + 11), and `seq_busy` falls on the same edge.
REQ-034 Scenario: drop `pll_lock` for 1 cycle in STRETCH at count 5 → counter restarts and `cpu_rstn` stays low for a further full 8 cycles after relock.
REQ-035 Scenario (DEB_CYC = 4, SOFT_CYC = 3): bounce the button low/high every 2 cycles, then hold it low → exactly one `soft_rstn` low pulse, 3 cycles wide, with `rst_cause` = 10 and `cpu_rstn` staying 1.
REQ-036 Scenario: `wdt_rst_req` and lock loss on the same RUN cycle → LOCK is entered, `cpu_rstn` = 0, `rst_cause` = 01, and no `soft_rstn` pulse occurs.
REQ-037 Scenario: `wdt_rst_req` pulsed during SOFT → pulse ignored, and SOFT still lasts exactly SOFT_CYC cycles.
REQ-038 Scenario: assert `reset` mid-SOFT → `cpu_rstn` = 0, `soft_rstn` = 1 and `rst_cause` = 00 immediately, without waiting for a clock edge.
